vga_init_master: RTL and testbench
==================================

Name: vga_init_master

Overview:
- Wishbone initiator that drives the VGA slave port. It is the other end of the VGA block's wb_* interface.
- On a start pulse it executes a script of entries read from a synchronous table ROM:
  - single I/O-register writes with wb_tga=1 (config interface),
  - memory fills with wb_tga=0 (video RAM),
  - polls of a status register, e.g. waiting for v_retrace.
- Used for hardware mode-set at boot and for screen clears without CPU involvement. Sits between the boot controller and the VGA slave, muxed with the CPU bus.

Parameters:
- TBL_AW, 6, table address width (up to 64 entries).
- ACK_TIMEOUT, 255, number of cycles in a bus cycle without wb_ack_i before aborting.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  reset. Synchronous and active-low, sampled on the rising edge of wb_clk_i.
- start_i  in  1  one-cycle pulse that starts the script at entry 0. Ignored while busy_o=1.
- busy_o  out  1  high from the cycle after start is accepted until DONE completes.
- done_o  out  1  one-cycle pulse when the script ends.
- err_o  out  1  sticky error flag (ack timeout or poll timeout). Cleared on the next accepted start.
- tbl_adr_o  out  TBL_AW  table ROM address.
- tbl_dat_i  in  48  table entry, valid one cycle after tbl_adr_o.
- wb_adr_o  out  16  word address [16:1].
- wb_dat_o  out  16  write data.
- wb_dat_i  in  16  read data.
- wb_we_o  out  1  write enable.
- wb_tga_o  out  1  1 = I/O config space, 0 = memory.
- wb_sel_o  out  2  byte selects.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle.
- wb_ack_i  in  1  acknowledge.

Behaviour:
- Entry format, 48 bits:
  - [47:46] op: 00 END, 01 IOW, 10 FILL, 11 POLL.
  - [45:44] sel.
  - [43:32] cnt (12-bit).
  - [31:16] adr.
  - [15:0] dat.
- Reset values: all outputs 0, tbl_adr_o=0, state IDLE, err_o=0. Reset mid-script drops wb_cyc_o/wb_stb_o in the same edge; no done_o pulse.
- FSM states and transitions:
  - IDLE: start_i=1 → ptr=0, err_o=0, go to FETCH.
  - FETCH: tbl_adr_o=ptr; wait one cycle for ROM latency.
  - DECODE: latch the entry into op/sel/cnt/adr/dat registers.
    - END → DONE.
    - Otherwise → BUS, with wb_cyc_o=wb_stb_o=1 on the next cycle.
  - BUS: hold adr/dat/sel/we/tga stable until wb_ack_i.
    - wb_tga_o = 1 for IOW and POLL, 0 for FILL.
    - wb_we_o = 1 for IOW and FILL, 0 for POLL.
  - GAP: one cycle with cyc/stb=0, then back to BUS. Used between POLL retries only.
  - DONE: done_o=1 for one cycle, busy_o=0 from the next cycle, return to IDLE.
- Latency: start_i sampled at edge N → wb_stb_o high after edge N+3.
- IOW: a single write. On ack, ptr+1 → FETCH, with cyc/stb low during FETCH/DECODE.
- FILL: writes cnt+1 words at adr, adr+1, …
  - cyc/stb stay high between words.
  - Each ack advances adr by 1 (16-bit wrap, 16'hFFFF → 16'h0000) and decrements cnt.
  - Ack with cnt=0 ends the entry. cnt=12'hFFF gives 4096 words.
- POLL: read at adr.
  - On ack with (wb_dat_i & dat) != 0 → entry done.
  - On ack with no match and cnt≠0 → cnt−1, go to GAP.
  - On ack with no match and cnt=0 → err_o=1, go to DONE (script aborted).
- Ack timeout: a per-bus-cycle counter resets on each ack or each new strobe. When it reaches ACK_TIMEOUT → drop cyc/stb, err_o=1, go to DONE.
- Table end: if ptr=2^TBL_AW−1 and that entry is not END, execute it, then go to DONE. ptr never wraps.
- start_i while busy: ignored, no side effects.
- start_i in the same cycle as the done_o pulse: ignored. It is accepted only in IDLE.
- wb_ack_i outside BUS: ignored.

Test Plan:
- Script [IOW adr=16'h01E2 dat=16'h0005 sel=2'b11; END], zero-wait ack → exactly one write with tga=1, adr=16'h01E2, dat=16'h0005. stb rises 3 cycles after start. done_o pulses once. err_o=0.
- FILL adr=16'hFFFE cnt=3 dat=16'h0720, slave acks every 2nd cycle → 4 writes to adr FFFE, FFFF, 0000, 0001 with tga=0. cyc stays high throughout.
- POLL adr=16'h01ED dat=16'h0008 cnt=5, slave returns 0 twice then 16'h0008 → 3 reads, each separated by one GAP cycle. err_o=0, next entry executed.
- POLL cnt=1, slave always returns 0 → 2 reads, then err_o=1 and done_o. Following entries are not executed.
- Slave never acks, ACK_TIMEOUT=255 → cyc/stb drop after 255 cycles, err_o=1, done_o pulses. A new start clears err_o.
- wb_rst_i=0 asserted in the middle of a FILL → all outputs 0 on the next edge. start_i held during busy → no restart. Full 64-entry table with no END → 64 ops executed, then done_o.

Source files
------------

// File: rtl/vga_init_master_if.sv
// Wishbone signal bundle between the VGA init master and the VGA slave port.
interface vga_init_master_if;
    logic [15:0] wb_adr_o;
    logic [15:0] wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_we_o;
    logic        wb_tga_o;
    logic [1:0]  wb_sel_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_tga_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_tga_o, wb_sel_o, wb_stb_o, wb_cyc_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/vga_init_master.sv
// Script-driven Wishbone initiator for the VGA slave: runs register writes,
// memory fills and status polls from a synchronous table ROM.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start_i
// FETCH   | table address presented, ROM access in flight
// DECODE  | entry latched into op/sel/cnt/adr/dat
// BUS     | bus cycle; first cycle raises cyc/stb, then waits for ack
// GAP     | one idle bus cycle between POLL retries
// DONE    | done_o pulse, back to IDLE
module vga_init_master #(
    parameter int TBL_AW      = 6,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [TBL_AW-1:0] tbl_adr_o,
    input  logic [47:0]       tbl_dat_i,
    vga_init_master_if.master wb
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0]     TMO_LOAD = TW'(ACK_TIMEOUT - 1);
    localparam logic [TBL_AW-1:0] PTR_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_BUS, S_GAP, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_END = 2'b00, OP_IOW = 2'b01, OP_FILL = 2'b10, OP_POLL = 2'b11
    } op_t;

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [TBL_AW-1:0] ptr_q, ptr_d;
    logic [1:0]        sel_q, sel_d;
    logic [11:0]       cnt_q, cnt_d;
    logic [15:0]       adr_q, adr_d;
    logic [15:0]       dat_q, dat_d;
    logic              we_q, we_d;
    logic              tga_q, tga_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              next_entry;

    // Next-state and next-output computation for the script sequencer.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        tga_d      = tga_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        tmo_d      = tmo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        next_entry = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ptr_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d  = op_t'(tbl_dat_i[47:46]);
                sel_d = tbl_dat_i[45:44];
                cnt_d = tbl_dat_i[43:32];
                adr_d = tbl_dat_i[31:16];
                dat_d = tbl_dat_i[15:0];
                we_d  = (tbl_dat_i[47:46] != 2'b11);
                tga_d = (tbl_dat_i[47:46] != 2'b10);
                if (tbl_dat_i[47:46] == 2'b00) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (!stb_q) begin
                    // launch cycle: acks are not looked at until strobe is out
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                    tmo_d = TMO_LOAD;
                end else if (wb.wb_ack_i) begin
                    tmo_d = TMO_LOAD;
                    case (op_q)
                        OP_FILL: begin
                            adr_d = adr_q + 16'd1;
                            if (cnt_q == 12'd0) next_entry = 1'b1;
                            else                cnt_d = cnt_q - 12'd1;
                        end
                        OP_POLL: begin
                            if ((wb.wb_dat_i & dat_q) != 16'd0) begin
                                next_entry = 1'b1;
                            end else if (cnt_q != 12'd0) begin
                                cnt_d   = cnt_q - 12'd1;
                                cyc_d   = 1'b0;
                                stb_d   = 1'b0;
                                state_d = S_GAP;
                            end else begin
                                cyc_d   = 1'b0;
                                stb_d   = 1'b0;
                                err_d   = 1'b1;
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                        default: next_entry = 1'b1;
                    endcase
                end else if (tmo_q == '0) begin
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end

                if (next_entry) begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                    if (ptr_q == PTR_MAX) begin
                        // last table slot executed: stop rather than wrap
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_GAP: begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                tmo_d   = TMO_LOAD;
                state_d = S_BUS;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset drops the bus in the same edge.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
            op_q    <= OP_END;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            tga_q   <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            tga_q   <= tga_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign tbl_adr_o   = ptr_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_tga_o = tga_q;
    assign wb.wb_sel_o = sel_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;
endmodule

// File: tb/tb_vga_init_master.sv
// Directed bench for vga_init_master: table ROM, configurable slave, transfer log.
module tb_vga_init_master;
    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, err_o;
    logic [5:0]  tbl_adr_o;
    logic [47:0] tbl_dat_i = '0;

    vga_init_master_if bus();

    vga_init_master dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst_b),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .tbl_adr_o (tbl_adr_o),
        .tbl_dat_i (tbl_dat_i),
        .wb        (bus)
    );

    always #5 clk = ~clk;

    logic [47:0] rom [0:63];
    logic [15:0] resp [0:255];
    int          ack_mode = 0;   // 0 zero-wait, 1 every 2nd cycle, 2 never
    logic        phase = 1'b0;

    int          n_xfer = 0, n_rd = 0, n_done = 0, stb_hi = 0, cyc_rise = 0, cyc_n = 0;
    logic        cyc_prev = 1'b0;
    logic [15:0] xf_adr [0:255];
    logic [15:0] xf_dat [0:255];
    logic        xf_we  [0:255];
    logic        xf_tga [0:255];
    logic [1:0]  xf_sel [0:255];
    int          xf_t   [0:255];

    int n_chk = 0, n_bad = 0;

    always @(posedge clk) tbl_dat_i <= rom[tbl_adr_o];

    always_comb begin
        bus.wb_ack_i = bus.wb_cyc_o & bus.wb_stb_o &
                       ((ack_mode == 0) ? 1'b1 : (ack_mode == 1) ? phase : 1'b0);
        bus.wb_dat_i = (n_rd < 256) ? resp[n_rd] : 16'h0000;
    end

    // transfer log and event counters
    always @(posedge clk) begin
        if (bus.wb_cyc_o && bus.wb_stb_o && bus.wb_ack_i && n_xfer < 256) begin
            xf_adr[n_xfer] <= bus.wb_adr_o;
            xf_dat[n_xfer] <= bus.wb_dat_o;
            xf_we[n_xfer]  <= bus.wb_we_o;
            xf_tga[n_xfer] <= bus.wb_tga_o;
            xf_sel[n_xfer] <= bus.wb_sel_o;
            xf_t[n_xfer]   <= cyc_n;
            n_xfer         <= n_xfer + 1;
            if (!bus.wb_we_o) n_rd <= n_rd + 1;
        end
        if (done_o) n_done <= n_done + 1;
        if (bus.wb_stb_o) stb_hi <= stb_hi + 1;
        if (bus.wb_cyc_o && !cyc_prev) cyc_rise <= cyc_rise + 1;
        cyc_prev <= bus.wb_cyc_o;
        phase    <= (bus.wb_cyc_o && bus.wb_stb_o) ? ~phase : 1'b0;
        cyc_n    <= cyc_n + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] ent(input logic [1:0] op, input logic [1:0] sel,
                                        input logic [11:0] cnt, input logic [15:0] adr,
                                        input logic [15:0] dat);
        return {op, sel, cnt, adr, dat};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 48'h0;
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (!done_o && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_seen"}, {31'd0, done_o}, 32'd1);
        @(negedge clk);
        chk({tag, "_busy_after"}, {31'd0, busy_o}, 32'd0);
    endtask

    int bx, bd, bc, bs, br, k;

    initial begin
        for (int i = 0; i < 256; i++) resp[i] = 16'h0000;
        clear_rom();
        repeat (3) @(negedge clk);
        chk("rst_outs", {busy_o, done_o, err_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
                         bus.wb_tga_o, bus.wb_sel_o}, 32'd0);
        chk("rst_adr", {tbl_adr_o, bus.wb_adr_o}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // single IOW, zero-wait
        rom[0] = ent(2'b01, 2'b11, 12'd0, 16'h01E2, 16'h0005);
        bx = n_xfer; bd = n_done; bc = cyc_rise;
        start_pulse();
        k = 1;
        while (!bus.wb_stb_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("iow_stb_latency", k, 4);
        wait_done("iow", 50);
        chk("iow_count", n_xfer - bx, 1);
        chk("iow_adr", xf_adr[bx], 16'h01E2);
        chk("iow_dat", xf_dat[bx], 16'h0005);
        chk("iow_we_tga_sel", {xf_we[bx], xf_tga[bx], xf_sel[bx]}, 4'b1111);
        chk("iow_done_cnt", n_done - bd, 1);
        chk("iow_cyc_rises", cyc_rise - bc, 1);
        chk("iow_err", err_o, 0);

        // FILL across the address wrap, slave acks every 2nd cycle
        clear_rom();
        rom[0] = ent(2'b10, 2'b11, 12'd3, 16'hFFFE, 16'h0720);
        ack_mode = 1;
        bx = n_xfer; bc = cyc_rise;
        start_pulse();
        wait_done("fill", 100);
        chk("fill_count", n_xfer - bx, 4);
        chk("fill_adr0", xf_adr[bx],     16'hFFFE);
        chk("fill_adr1", xf_adr[bx + 1], 16'hFFFF);
        chk("fill_adr2", xf_adr[bx + 2], 16'h0000);
        chk("fill_adr3", xf_adr[bx + 3], 16'h0001);
        chk("fill_tga_we", {xf_tga[bx], xf_tga[bx + 3], xf_we[bx], xf_we[bx + 3]}, 4'b0011);
        chk("fill_dat3", xf_dat[bx + 3], 16'h0720);
        chk("fill_cyc_rises", cyc_rise - bc, 1);

        // POLL that matches on the third read, then one more entry
        clear_rom();
        rom[0] = ent(2'b11, 2'b11, 12'd5, 16'h01ED, 16'h0008);
        rom[1] = ent(2'b01, 2'b01, 12'd0, 16'h03C0, 16'h1234);
        ack_mode = 0;
        br = n_rd;
        resp[br] = 16'hFFF7; resp[br + 1] = 16'h0000; resp[br + 2] = 16'h0008;
        bx = n_xfer;
        start_pulse();
        wait_done("poll", 100);
        chk("poll_count", n_xfer - bx, 4);
        chk("poll_reads", n_rd - br, 3);
        chk("poll_rd_attr", {xf_we[bx], xf_tga[bx], xf_we[bx + 2], xf_tga[bx + 2]}, 4'b0101);
        chk("poll_rd_adr", xf_adr[bx + 1], 16'h01ED);
        chk("poll_gap01", xf_t[bx + 1] - xf_t[bx], 2);
        chk("poll_gap12", xf_t[bx + 2] - xf_t[bx + 1], 2);
        chk("poll_next_adr", xf_adr[bx + 3], 16'h03C0);
        chk("poll_next_dat_sel", {xf_dat[bx + 3], 14'd0, xf_sel[bx + 3]}, {16'h1234, 16'h0001});
        chk("poll_err", err_o, 0);

        // POLL exhausting retries aborts the script
        clear_rom();
        rom[0] = ent(2'b11, 2'b11, 12'd1, 16'h01DA, 16'h0008);
        rom[1] = ent(2'b01, 2'b11, 12'd0, 16'h03C0, 16'h5555);
        bx = n_xfer; bd = n_done;
        start_pulse();
        wait_done("pollto", 100);
        chk("pollto_count", n_xfer - bx, 2);
        chk("pollto_err", err_o, 1);
        chk("pollto_done", n_done - bd, 1);

        // ack timeout, then a fresh start clears err_o
        clear_rom();
        rom[0] = ent(2'b01, 2'b11, 12'd0, 16'h0100, 16'h00FF);
        ack_mode = 2;
        bs = stb_hi; bd = n_done; bx = n_xfer;
        start_pulse();
        wait_done("tmo", 400);
        chk("tmo_stb_cycles", stb_hi - bs, 255);
        chk("tmo_err", err_o, 1);
        chk("tmo_done", n_done - bd, 1);
        chk("tmo_bus_idle", {bus.wb_cyc_o, bus.wb_stb_o}, 0);
        chk("tmo_no_xfer", n_xfer - bx, 0);
        clear_rom();
        ack_mode = 0;
        start_pulse();
        chk("restart_err_clr", err_o, 0);
        wait_done("restart", 50);

        // reset in the middle of a long FILL
        rom[0] = ent(2'b10, 2'b10, 12'd100, 16'h1000, 16'hAAAA);
        ack_mode = 1;
        bx = n_xfer; bd = n_done;
        start_pulse();
        k = 0;
        while ((n_xfer - bx) < 3 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rstmid_progress", ((n_xfer - bx) >= 3), 1);
        rst_b = 1'b0;
        @(negedge clk);
        chk("rstmid_outs", {busy_o, done_o, err_o, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o,
                            bus.wb_tga_o, bus.wb_sel_o}, 32'd0);
        chk("rstmid_adr", {tbl_adr_o, bus.wb_adr_o, bus.wb_dat_o}, 32'd0);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstmid_no_done", n_done - bd, 0);

        // start held high for the whole run: no restart
        clear_rom();
        rom[0] = ent(2'b01, 2'b11, 12'd0, 16'h0010, 16'h0001);
        rom[1] = ent(2'b01, 2'b11, 12'd0, 16'h0011, 16'h0002);
        bx = n_xfer; bd = n_done;
        @(negedge clk);
        start_i = 1'b1;
        k = 0;
        while (!done_o && k < 100) begin
            @(negedge clk);
            k++;
        end
        start_i = 1'b0;
        chk("hold_done_seen", done_o, 1);
        repeat (3) @(negedge clk);
        chk("hold_busy", busy_o, 0);
        chk("hold_count", n_xfer - bx, 2);
        chk("hold_done_cnt", n_done - bd, 1);

        // full table without END stops after the last slot
        for (int i = 0; i < 64; i++)
            rom[i] = ent(2'b01, 2'b11, 12'd0, 16'(i), 16'(16'h0100 + i));
        ack_mode = 0;
        bx = n_xfer; bd = n_done;
        start_pulse();
        wait_done("full", 1000);
        chk("full_count", n_xfer - bx, 64);
        chk("full_first", xf_adr[bx], 16'h0000);
        chk("full_last", {xf_adr[bx + 63], xf_dat[bx + 63]}, {16'h003F, 16'h013F});
        chk("full_tbl_adr", tbl_adr_o, 6'd63);
        chk("full_done_cnt", n_done - bd, 1);
        chk("full_err", err_o, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
